cordic_iter: RTL
================

Name: cordic_iter

Overview:
Parametrised iterative circular CORDIC engine, successor to the fixed 20-bit core. Supports rotation and vectoring modes per transaction, full-circle inputs via quadrant pre-rotation, configurable width and iteration count, and a valid/ready handshake with output backpressure. Sits between the control FSM and downstream trig/magnitude consumers.

Parameters:
W, 20, input/angle word width (bits); legal 8..32
ITER, 16, number of micro-rotations; legal 4..W
ANGLE_LUT_W, 32, precision of the internal atan constant table before it is scaled to W

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  input transaction valid
in_ready  out  1  core can accept an input
mode  in  1  0 = rotation, 1 = vectoring; sampled on accept
x_in  in  W  signed x
y_in  in  W  signed y
z_in  in  W  signed angle, binary radians: 2^(W-2) = pi/2, wraps mod 2^W
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
busy  out  1  high from accept until result is consumed
x_out  out  W+2  signed x result, includes CORDIC gain K≈1.64676
y_out  out  W+2  signed y result
z_out  out  W  signed residual/accumulated angle, binary radians

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; in_ready=1 once reset deasserts; out_valid=0; busy=0; x_out, y_out, z_out=0; iteration counter=0.
- FSM states: IDLE, PRE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch mode, sign-extend x_in/y_in to W+2, latch z_in, go to PRE, busy=1.
- PRE (1 cycle), quadrant pre-rotation:
  - Rotation mode, z > 2^(W-2): (x,y) <= (-y, x), z <= z - 2^(W-2).
  - Rotation mode, z < -2^(W-2): (x,y) <= (y, -x), z <= z + 2^(W-2).
  - Vectoring mode, x < 0 and y >= 0: (x,y) <= (y, -x), z <= z + 2^(W-2).
  - Vectoring mode, x < 0 and y < 0: (x,y) <= (-y, x), z <= z - 2^(W-2).
  - Otherwise unchanged. Counter=0. Go to CALC.
- CALC: one micro-rotation per cycle for i = 0..ITER-1.
  - Direction d=+1 if (rotation: z>=0) or (vectoring: y<0); otherwise d=-1.
  - x <= x - d*(y>>>i); y <= y + d*(x>>>i); z <= z - d*atan_i.
  - All updates use old values. Shifts are arithmetic. x/y arithmetic is W+2 bits and z arithmetic is W bits, wrapping modulo.
  - After the i=ITER-1 update, go to DONE.
- atan_i = round(atan(2^-i) * 2^(ANGLE_LUT_W-1)/pi), right-shifted by ANGLE_LUT_W-W with round-half-up. The table is a constant function/ROM, synthesisable, with no external memory.
- DONE: out_valid=1 and x_out/y_out/z_out hold the final values, stable while out_valid=1 and out_ready=0. in_ready=0.
  - On out_ready=1: out_valid<=0, busy<=0, go to IDLE. Outputs retain their last values.
- Latency: accept edge -> out_valid high after exactly ITER+2 rising edges. Throughput is one transaction per ITER+3 cycles minimum.
- in_valid while not in IDLE is ignored (no accept, since in_ready=0).
- mode and inputs changing after accept have no effect.
- Reset asserted mid-operation: aborts immediately to reset values. No partial result is emitted.
- No gain compensation: x_out/y_out carry K. Worst-case |x|,|y| <= K*sqrt(2)*2^(W-1) < 2^(W+1), so W+2 bits never overflow.
- Accuracy: results are within ±(ITER+2) LSB of ideal for ITER=W-4.

Test Plan:
- Reset: W=20, hold reset=0 mid-CALC, release -> out_valid=0, busy=0, in_ready=1, outputs 0, and no spurious out_valid afterwards.
- Rotation: mode=0, x=100000, y=0, z=0 -> x_out≈164676, y_out≈0, z_out≈0 (±18 LSB). out_valid rises exactly 18 edges after accept (ITER=16).
- Rotation with pre-rotation: mode=0, x=100000, y=0, z=393216 (3pi/4) -> x_out≈-116444, y_out≈116444, z_out≈0.
- Vectoring: mode=0→1, x=100000, y=100000, z=0 -> x_out≈232887, y_out≈0, z_out≈131072 (pi/4).
- Vectoring left half-plane: x=-100000, y=-1, z=0 -> x_out≈164676, y_out≈0, z_out≈-524288 (±18 LSB mod 2^20).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new data -> out_valid and outputs stable, in_ready=0, no accept. out_ready=1 -> out_valid falls next edge; the next in_valid is accepted from IDLE.

Source files
------------

// File: rtl/cordic_iter_if.sv
// Handshake and data bundle between the CORDIC engine and its producer/consumer.
// The slave modport is the engine side; the master modport is the requester side.
interface cordic_iter_if #(
    parameter int W = 20
);
    logic                in_valid;
    logic                in_ready;
    logic                mode;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic signed [W-1:0] z_in;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic signed [W+1:0] x_out;
    logic signed [W+1:0] y_out;
    logic signed [W-1:0] z_out;

    modport master (
        output in_valid, mode, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, busy, x_out, y_out, z_out
    );

    modport slave (
        input  in_valid, mode, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, busy, x_out, y_out, z_out
    );
endinterface

// File: rtl/cordic_iter.sv
// Iterative circular CORDIC: quadrant pre-rotation, then ITER micro-rotations,
// rotation or vectoring mode per transaction, valid/ready on both sides.
module cordic_iter #(
    parameter int W           = 20,
    parameter int ITER        = 16,
    parameter int ANGLE_LUT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    cordic_iter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic signed [W-1:0] C_QUARTER  = {2'b01, {(W-2){1'b0}}};
    localparam logic signed [W-1:0] C_NQUARTER = {2'b11, {(W-2){1'b0}}};
    localparam logic [5:0]          C_LAST     = 6'(ITER - 1);

    // atan(2^-i) in binary radians with 2^32 per full turn
    function automatic logic [31:0] atan_lut32(input logic [5:0] idx);
        case (idx)
            6'd0:  atan_lut32 = 32'd536870912;
            6'd1:  atan_lut32 = 32'd316933406;
            6'd2:  atan_lut32 = 32'd167458907;
            6'd3:  atan_lut32 = 32'd85004756;
            6'd4:  atan_lut32 = 32'd42667331;
            6'd5:  atan_lut32 = 32'd21354465;
            6'd6:  atan_lut32 = 32'd10679838;
            6'd7:  atan_lut32 = 32'd5340245;
            6'd8:  atan_lut32 = 32'd2670163;
            6'd9:  atan_lut32 = 32'd1335087;
            6'd10: atan_lut32 = 32'd667544;
            6'd11: atan_lut32 = 32'd333772;
            6'd12: atan_lut32 = 32'd166886;
            6'd13: atan_lut32 = 32'd83443;
            6'd14: atan_lut32 = 32'd41722;
            6'd15: atan_lut32 = 32'd20861;
            6'd16: atan_lut32 = 32'd10430;
            6'd17: atan_lut32 = 32'd5215;
            6'd18: atan_lut32 = 32'd2608;
            6'd19: atan_lut32 = 32'd1304;
            6'd20: atan_lut32 = 32'd652;
            6'd21: atan_lut32 = 32'd326;
            6'd22: atan_lut32 = 32'd163;
            6'd23: atan_lut32 = 32'd81;
            6'd24: atan_lut32 = 32'd41;
            6'd25: atan_lut32 = 32'd20;
            6'd26: atan_lut32 = 32'd10;
            6'd27: atan_lut32 = 32'd5;
            6'd28: atan_lut32 = 32'd3;
            6'd29: atan_lut32 = 32'd1;
            6'd30: atan_lut32 = 32'd1;
            default: atan_lut32 = 32'd0;
        endcase
    endfunction

    function automatic logic [32:0] round_shift(input logic [32:0] v, input int s);
        if (s <= 0) begin
            round_shift = v;
        end else begin
            round_shift = (v + (33'd1 << (s - 1))) >> s;
        end
    endfunction

    function automatic logic [W-1:0] atan_w(input logic [5:0] idx);
        logic [32:0] v;
        v      = round_shift({1'b0, atan_lut32(idx)}, 32 - ANGLE_LUT_W);
        v      = round_shift(v, ANGLE_LUT_W - W);
        atan_w = v[W-1:0];
    endfunction

    state_t              r_state,  w_state_nx;
    logic                r_mode,   w_mode_nx;
    logic signed [W+1:0] r_x,      w_x_nx;
    logic signed [W+1:0] r_y,      w_y_nx;
    logic signed [W-1:0] r_z,      w_z_nx;
    logic [5:0]          r_cnt,    w_cnt_nx;
    logic                r_in_ready,  w_in_ready_nx;
    logic                r_out_valid, w_out_valid_nx;
    logic                r_busy,      w_busy_nx;
    logic signed [W+1:0] r_x_out,  w_x_out_nx;
    logic signed [W+1:0] r_y_out,  w_y_out_nx;
    logic signed [W-1:0] r_z_out,  w_z_out_nx;

    logic                w_dir;
    logic signed [W+1:0] w_x_sh, w_y_sh, w_x_rot, w_y_rot;
    logic signed [W-1:0] w_atan, w_z_rot;

    // d=+1 when rotating toward z=0 (rotation) or toward y=0 from below (vectoring)
    assign w_dir   = r_mode ? r_y[W+1] : ~r_z[W-1];
    assign w_x_sh  = r_x >>> r_cnt;
    assign w_y_sh  = r_y >>> r_cnt;
    assign w_atan  = atan_w(r_cnt);
    assign w_x_rot = w_dir ? (r_x - w_y_sh) : (r_x + w_y_sh);
    assign w_y_rot = w_dir ? (r_y + w_x_sh) : (r_y - w_x_sh);
    assign w_z_rot = w_dir ? (r_z - w_atan) : (r_z + w_atan);

    // Next-state and next-datapath logic
    always_comb begin
        w_state_nx     = r_state;
        w_mode_nx      = r_mode;
        w_x_nx         = r_x;
        w_y_nx         = r_y;
        w_z_nx         = r_z;
        w_cnt_nx       = r_cnt;
        w_in_ready_nx  = r_in_ready;
        w_out_valid_nx = r_out_valid;
        w_busy_nx      = r_busy;
        w_x_out_nx     = r_x_out;
        w_y_out_nx     = r_y_out;
        w_z_out_nx     = r_z_out;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_mode_nx     = bus.mode;
                    w_x_nx        = {{2{bus.x_in[W-1]}}, bus.x_in};
                    w_y_nx        = {{2{bus.y_in[W-1]}}, bus.y_in};
                    w_z_nx        = bus.z_in;
                    w_in_ready_nx = 1'b0;
                    w_busy_nx     = 1'b1;
                    w_state_nx    = S_PRE;
                end else begin
                    w_state_nx    = S_IDLE;
                end
            end
            S_PRE: begin
                if (!r_mode) begin
                    if (r_z > C_QUARTER) begin
                        w_x_nx = -r_y;
                        w_y_nx = r_x;
                        w_z_nx = r_z - C_QUARTER;
                    end else if (r_z < C_NQUARTER) begin
                        w_x_nx = r_y;
                        w_y_nx = -r_x;
                        w_z_nx = r_z + C_QUARTER;
                    end else begin
                        w_x_nx = r_x;
                    end
                end else begin
                    if (r_x[W+1] && !r_y[W+1]) begin
                        w_x_nx = r_y;
                        w_y_nx = -r_x;
                        w_z_nx = r_z + C_QUARTER;
                    end else if (r_x[W+1]) begin
                        w_x_nx = -r_y;
                        w_y_nx = r_x;
                        w_z_nx = r_z - C_QUARTER;
                    end else begin
                        w_x_nx = r_x;
                    end
                end
                w_cnt_nx   = 6'd0;
                w_state_nx = S_CALC;
            end
            S_CALC: begin
                w_x_nx = w_x_rot;
                w_y_nx = w_y_rot;
                w_z_nx = w_z_rot;
                if (r_cnt == C_LAST) begin
                    w_x_out_nx     = w_x_rot;
                    w_y_out_nx     = w_y_rot;
                    w_z_out_nx     = w_z_rot;
                    w_out_valid_nx = 1'b1;
                    w_state_nx     = S_DONE;
                end else begin
                    w_cnt_nx       = r_cnt + 6'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_out_valid_nx = 1'b0;
                    w_busy_nx      = 1'b0;
                    w_in_ready_nx  = 1'b1;
                    w_state_nx     = S_IDLE;
                end else begin
                    w_state_nx     = S_DONE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_cnt       <= 6'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_x_out     <= '0;
            r_y_out     <= '0;
            r_z_out     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_mode      <= w_mode_nx;
            r_x         <= w_x_nx;
            r_y         <= w_y_nx;
            r_z         <= w_z_nx;
            r_cnt       <= w_cnt_nx;
            r_in_ready  <= w_in_ready_nx;
            r_out_valid <= w_out_valid_nx;
            r_busy      <= w_busy_nx;
            r_x_out     <= w_x_out_nx;
            r_y_out     <= w_y_out_nx;
            r_z_out     <= w_z_out_nx;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.x_out     = r_x_out;
    assign bus.y_out     = r_y_out;
    assign bus.z_out     = r_z_out;
endmodule
